// File: rtl/systolic_seq_ctrl_pkg.sv
// Shared constants and FSM state type for the 4x4 systolic array sequencer.
package systolic_pkg;

    localparam int N         = 4;
    localparam int DW        = 8;
    localparam int RW        = 16;
    localparam int FEED_CYC  = 2 * N - 1;
    localparam int DRAIN_CYC = N;
    localparam int CNT_W     = $clog2(FEED_CYC + 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/systolic_seq_ctrl_if.sv
// Host-side bundle: matrix row loads, start/busy/done, captured product.
interface systolic_seq_ctrl_if #(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW,
    parameter int RW = systolic_pkg::RW
);
    logic                   ld_valid;
    logic                   ld_ready;
    logic                   ld_sel;
    logic [$clog2(N)-1:0]   ld_row;
    logic [N*DW-1:0]        ld_data;
    logic                   start;
    logic                   busy;
    logic                   done;
    logic [N*N*RW-1:0]      res;
    logic                   res_valid;

    modport master (
        output ld_valid, ld_sel, ld_row, ld_data, start,
        input  ld_ready, busy, done, res, res_valid
    );

    modport slave (
        input  ld_valid, ld_sel, ld_row, ld_data, start,
        output ld_ready, busy, done, res, res_valid
    );
endinterface

// File: rtl/systolic_seq_ctrl_skew_feeder.sv
// Diagonal skew select: row i of A and column j of B enter the array
// delayed by i (resp. j) cycles, with zeros outside each operand window.
module skew_feeder
    import systolic_pkg::*;
#(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW
) (
    input  logic [N-1:0][N-1:0][DW-1:0] a_buf,
    input  logic [N-1:0][N-1:0][DW-1:0] b_buf,
    input  logic [CNT_W-1:0]            t,
    output logic [N*DW-1:0]             a_sel,
    output logic [N*DW-1:0]             b_sel
);
    localparam int IW = $clog2(N);

    // Element k = t - lane feeds lane; lanes outside 0..N-1 get zero.
    always_comb begin
        int k;
        k     = 0;
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < N; i++) begin
            k = int'(t) - i;
            if (k >= 0 && k < N) begin
                a_sel[i*DW +: DW] = a_buf[i][k[IW-1:0]];
                b_sel[i*DW +: DW] = b_buf[k[IW-1:0]][i];
            end
        end
    end
endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 4x4 output-stationary MAC array: buffers A/B, clears
// the array, streams skewed feeds, waits for drain and captures C = A*B.
module systolic_seq_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = systolic_pkg::N,
    parameter int DW = systolic_pkg::DW,
    parameter int RW = systolic_pkg::RW
) (
    input  logic                 clk,
    input  logic                 rst,
    systolic_seq_ctrl_if.slave   host,
    output logic                 arr_clr,
    output logic [N*DW-1:0]      a_feed,
    output logic [N*DW-1:0]      b_feed,
    input  logic [N*N*RW-1:0]    arr_res
);
    state_t                      state;
    logic [CNT_W-1:0]            cnt;
    logic [CNT_W-1:0]            t_next;
    logic [N-1:0][N-1:0][DW-1:0] a_buf;
    logic [N-1:0][N-1:0][DW-1:0] b_buf;
    logic [N*DW-1:0]             a_skew;
    logic [N*DW-1:0]             b_skew;
    logic                        done_r;
    logic [N*N*RW-1:0]           res_r;
    logic                        res_valid_r;
    logic                        load_en;

    assign load_en        = host.ld_valid && (state == IDLE);
    assign host.ld_ready  = (state == IDLE);
    assign host.busy      = (state != IDLE);
    assign host.done      = done_r;
    assign host.res       = res_r;
    assign host.res_valid = res_valid_r;

    // Feeds are registered, so select the element for the FEED step about to begin.
    assign t_next = (state == FEED) ? cnt + CNT_W'(1) : '0;

    skew_feeder #(
        .N  (N),
        .DW (DW)
    ) u_skew (
        .a_buf (a_buf),
        .b_buf (b_buf),
        .t     (t_next),
        .a_sel (a_skew),
        .b_sel (b_skew)
    );

    // Host row writes into the operand buffers, accepted only while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_buf <= '0;
            b_buf <= '0;
        end else if (load_en) begin
            if (host.ld_sel) begin
                b_buf[host.ld_row] <= host.ld_data;
            end else begin
                a_buf[host.ld_row] <= host.ld_data;
            end
        end
    end

    // Run FSM with registered array controls, feeds and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            done_r      <= 1'b0;
            arr_clr     <= 1'b1;
            a_feed      <= '0;
            b_feed      <= '0;
            res_r       <= '0;
            res_valid_r <= 1'b0;
        end else begin
            done_r  <= 1'b0;
            arr_clr <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (host.start) begin
                        state       <= CLEAR;
                        cnt         <= '0;
                        arr_clr     <= 1'b1;
                        res_valid_r <= 1'b0;
                    end
                end
                CLEAR: begin
                    state  <= FEED;
                    cnt    <= '0;
                    a_feed <= a_skew;
                    b_feed <= b_skew;
                end
                FEED: begin
                    if (cnt == CNT_W'(FEED_CYC - 1)) begin
                        state  <= DRAIN;
                        cnt    <= '0;
                        a_feed <= '0;
                        b_feed <= '0;
                    end else begin
                        cnt    <= cnt + CNT_W'(1);
                        a_feed <= a_skew;
                        b_feed <= b_skew;
                    end
                end
                DRAIN: begin
                    if (cnt == CNT_W'(DRAIN_CYC - 1)) begin
                        state  <= DONE;
                        cnt    <= '0;
                        done_r <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    res_r       <= arr_res;
                    res_valid_r <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
